// File: rtl/inst_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// inst_fetch_ctrl : two-cycle SETUP/ACCESS instruction fetch sequencer.
// Optional macro FETCH_ALIGN_CHECK_EN: misaligned redirects halt the fetcher.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module inst_fetch_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h00000000,
  parameter int          MEM_BYTES = 256
) (
  input  logic        Clk,
  input  logic        Reset_n,
  output logic        MemEnable,
  output logic [31:0] MemAddress,
  input  logic [31:0] MemDataOut,
  input  logic        Stall,
  input  logic        BranchTaken,
  input  logic [31:0] BranchTarget,
  output logic [31:0] Instr,
  output logic        InstrValid,
  output logic [31:0] PC,
  output logic        FetchErr
);

  localparam logic [31:0] C_ADDR_MASK = 32'(MEM_BYTES - 1);

  typedef enum logic [1:0] {
    SETUP  = 2'd0,
    ACCESS = 2'd1,
    HALT   = 2'd2
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [31:0] r_fptr, w_fptr_nxt;
  logic [31:0] r_instr, w_instr_nxt;
  logic [31:0] r_pc, w_pc_nxt;
  logic        r_valid, w_valid_nxt;
  logic        r_err, w_err_nxt;
  logic [31:0] w_redirect;
  logic        w_misaligned;

  assign w_redirect = BranchTarget & ~32'h3 & C_ADDR_MASK;

`ifdef FETCH_ALIGN_CHECK_EN
  assign w_misaligned = |BranchTarget[1:0];
`else
  assign w_misaligned = 1'b0;
`endif

  assign MemAddress = r_fptr;
  assign Instr      = r_instr;
  assign PC         = r_pc;
  assign InstrValid = r_valid;
  assign FetchErr   = r_err;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state <= SETUP;
      r_fptr  <= RESET_PC;
      r_instr <= '0;
      r_pc    <= '0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_fptr  <= w_fptr_nxt;
      r_instr <= w_instr_nxt;
      r_pc    <= w_pc_nxt;
      r_valid <= w_valid_nxt;
      r_err   <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_fptr_nxt  = r_fptr;
    w_instr_nxt = r_instr;
    w_pc_nxt    = r_pc;
    w_valid_nxt = r_valid;
    w_err_nxt   = r_err;
    MemEnable   = 1'b0;

    // A held instruction is consumed on any cycle without back-pressure.
    if (r_state != HALT && !Stall) w_valid_nxt = 1'b0;

    case (r_state)
      SETUP: begin
        if (!Stall) w_state_nxt = ACCESS;
      end
      ACCESS: begin
        MemEnable   = 1'b1;
        w_instr_nxt = MemDataOut;
        w_pc_nxt    = r_fptr;
        w_valid_nxt = 1'b1;
        w_fptr_nxt  = (r_fptr + 32'd4) & C_ADDR_MASK;
        w_state_nxt = SETUP;
      end
      HALT: begin
      end
      default: w_state_nxt = SETUP;
    endcase

    // Redirect overrides both back-pressure and the capture of this cycle.
    if (BranchTaken && r_state != HALT) begin
      w_valid_nxt = 1'b0;
      w_instr_nxt = r_instr;
      w_pc_nxt    = r_pc;
      if (w_misaligned) begin
        w_err_nxt   = 1'b1;
        w_fptr_nxt  = r_fptr;
        w_state_nxt = HALT;
      end else begin
        w_fptr_nxt  = w_redirect;
        w_state_nxt = SETUP;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_inst_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_inst_fetch_ctrl : directed and randomized checks of inst_fetch_ctrl.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_inst_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        br = 1'b0;
  logic [31:0] br_tgt = '0;

  logic        mem_en, w_mem_en;
  logic [31:0] mem_addr, w_mem_addr;
  logic [31:0] mem_dout, w_mem_dout;
  logic [31:0] instr, w_instr;
  logic        instr_valid, w_instr_valid;
  logic [31:0] pc, w_pc;
  logic        fetch_err, w_fetch_err;

  logic [31:0] mem [0:63];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign mem_dout   = mem[mem_addr[7:2]];
  assign w_mem_dout = mem[w_mem_addr[7:2]];

  inst_fetch_ctrl dut (
    .Clk(clk), .Reset_n(rst_n),
    .MemEnable(mem_en), .MemAddress(mem_addr), .MemDataOut(mem_dout),
    .Stall(stall), .BranchTaken(br), .BranchTarget(br_tgt),
    .Instr(instr), .InstrValid(instr_valid), .PC(pc), .FetchErr(fetch_err)
  );

  inst_fetch_ctrl #(.RESET_PC(32'd252), .MEM_BYTES(256)) dut_wrap (
    .Clk(clk), .Reset_n(rst_n),
    .MemEnable(w_mem_en), .MemAddress(w_mem_addr), .MemDataOut(w_mem_dout),
    .Stall(stall), .BranchTaken(br), .BranchTarget(br_tgt),
    .Instr(w_instr), .InstrValid(w_instr_valid), .PC(w_pc), .FetchErr(w_fetch_err)
  );

  // Leaves the bench at a falling edge with both DUTs just out of reset.
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; stall = 1'b0; br = 1'b0; br_tgt = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (mem_en !== 1'b0 || mem_addr !== 32'd0 || instr !== 32'd0 || pc !== 32'd0 ||
        instr_valid !== 1'b0 || fetch_err !== 1'b0) begin
      n_err++;
      $display("FAIL reset: en=%b addr=%h instr=%h pc=%h valid=%b err=%b, want all zero",
               mem_en, mem_addr, instr, pc, instr_valid, fetch_err);
    end
    n_vec++;
    if (w_mem_addr !== 32'd252 || w_mem_en !== 1'b0 || w_pc !== 32'd0) begin
      n_err++;
      $display("FAIL reset_wrap: addr=%0d en=%b pc=%0d, want addr=252 en=0 pc=0",
               w_mem_addr, w_mem_en, w_pc);
    end
  endtask

  task automatic test_sequential();
    do_reset();
    for (int k = 1; k <= 8; k++) begin
      tick(1);
      n_vec++;
      if (k % 2 == 1) begin
        if (mem_en !== 1'b1 || mem_addr !== 32'(4 * ((k - 1) / 2)) || instr_valid !== 1'b0) begin
          n_err++;
          $display("FAIL seq_access k=%0d: en=%b addr=%0d valid=%b, want en=1 addr=%0d valid=0",
                   k, mem_en, mem_addr, instr_valid, 4 * ((k - 1) / 2));
        end
      end else begin
        if (mem_en !== 1'b0 || instr_valid !== 1'b1 || pc !== 32'(4 * (k / 2 - 1)) ||
            instr !== mem[k / 2 - 1] || mem_addr !== 32'(4 * (k / 2))) begin
          n_err++;
          $display("FAIL seq_capture k=%0d: en=%b valid=%b pc=%0d instr=%h addr=%0d, want en=0 valid=1 pc=%0d instr=%h addr=%0d",
                   k, mem_en, instr_valid, pc, instr, mem_addr,
                   4 * (k / 2 - 1), mem[k / 2 - 1], 4 * (k / 2));
        end
      end
    end
  endtask

  task automatic test_stall();
    do_reset();
    tick(2);
    stall = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick(1);
      n_vec++;
      if (instr !== 32'h11111111 || pc !== 32'd0 || instr_valid !== 1'b1 || mem_en !== 1'b0) begin
        n_err++;
        $display("FAIL stall_hold cyc=%0d: instr=%h pc=%0d valid=%b en=%b, want 11111111/0/1/0",
                 k, instr, pc, instr_valid, mem_en);
      end
    end
    stall = 1'b0;
    tick(1);
    n_vec++;
    if (mem_en !== 1'b1 || mem_addr !== 32'd4 || instr_valid !== 1'b0) begin
      n_err++;
      $display("FAIL stall_release: en=%b addr=%0d valid=%b, want en=1 addr=4 valid=0",
               mem_en, mem_addr, instr_valid);
    end
    // Back-pressure raised during an access must not abort the capture.
    stall = 1'b1;
    tick(1);
    n_vec++;
    if (instr !== 32'h22222222 || pc !== 32'd4 || instr_valid !== 1'b1 || mem_en !== 1'b0) begin
      n_err++;
      $display("FAIL stall_in_access: instr=%h pc=%0d valid=%b en=%b, want 22222222/4/1/0",
               instr, pc, instr_valid, mem_en);
    end
    tick(2);
    n_vec++;
    if (instr !== 32'h22222222 || instr_valid !== 1'b1 || mem_en !== 1'b0 || mem_addr !== 32'd8) begin
      n_err++;
      $display("FAIL stall_in_access_hold: instr=%h valid=%b en=%b addr=%0d, want 22222222/1/0/8",
               instr, instr_valid, mem_en, mem_addr);
    end
    stall = 1'b0;
  endtask

  task automatic test_branch();
    do_reset();
    tick(3);
    br = 1'b1; br_tgt = 32'd8;
    tick(1);
    br = 1'b0;
    n_vec++;
    if (instr_valid !== 1'b0 || pc !== 32'd0 || instr !== 32'h11111111 ||
        mem_en !== 1'b0 || mem_addr !== 32'd8) begin
      n_err++;
      $display("FAIL branch_cancel: valid=%b pc=%0d instr=%h en=%b addr=%0d, want 0/0/11111111/0/8",
               instr_valid, pc, instr, mem_en, mem_addr);
    end
    tick(2);
    n_vec++;
    if (instr_valid !== 1'b1 || pc !== 32'd8 || instr !== 32'h33333333) begin
      n_err++;
      $display("FAIL branch_target: valid=%b pc=%0d instr=%h, want 1/8/33333333",
               instr_valid, pc, instr);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int k = 0; k < 3; k++) begin
      tick(2);
      n_vec++;
      if (w_instr_valid !== 1'b1 || w_pc !== 32'((252 + 4 * k) % 256) ||
          w_instr !== mem[((252 + 4 * k) % 256) / 4]) begin
        n_err++;
        $display("FAIL wrap k=%0d: valid=%b pc=%0d instr=%h, want 1/%0d/%h",
                 k, w_instr_valid, w_pc, w_instr, (252 + 4 * k) % 256,
                 mem[((252 + 4 * k) % 256) / 4]);
      end
    end
  endtask

  task automatic test_align();
    do_reset();
    tick(2);
    br = 1'b1; br_tgt = 32'd6;
    tick(1);
    br = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
    for (int k = 0; k < 4; k++) begin
      n_vec++;
      if (fetch_err !== 1'b1 || mem_en !== 1'b0 || instr_valid !== 1'b0 || mem_addr !== 32'd4) begin
        n_err++;
        $display("FAIL align_halt cyc=%0d: err=%b en=%b valid=%b addr=%0d, want 1/0/0/4",
                 k, fetch_err, mem_en, instr_valid, mem_addr);
      end
      tick(1);
    end
`else
    n_vec++;
    if (fetch_err !== 1'b0 || mem_addr !== 32'd4 || instr_valid !== 1'b0) begin
      n_err++;
      $display("FAIL align_mask: err=%b addr=%0d valid=%b, want 0/4/0", fetch_err, mem_addr, instr_valid);
    end
    tick(2);
    n_vec++;
    if (instr_valid !== 1'b1 || pc !== 32'd4 || instr !== 32'h22222222 || fetch_err !== 1'b0) begin
      n_err++;
      $display("FAIL align_next: valid=%b pc=%0d instr=%h err=%b, want 1/4/22222222/0",
               instr_valid, pc, instr, fetch_err);
    end
`endif
  endtask

  task automatic test_reset_mid_access();
    do_reset();
    tick(3);
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if (mem_en !== 1'b0 || mem_addr !== 32'd0 || instr !== 32'd0 || pc !== 32'd0 ||
        instr_valid !== 1'b0 || fetch_err !== 1'b0) begin
      n_err++;
      $display("FAIL reset_mid: en=%b addr=%h instr=%h pc=%h valid=%b err=%b, want all zero",
               mem_en, mem_addr, instr, pc, instr_valid, fetch_err);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick(2);
    n_vec++;
    if (instr_valid !== 1'b1 || pc !== 32'd0 || instr !== 32'h11111111) begin
      n_err++;
      $display("FAIL reset_mid_restart: valid=%b pc=%0d instr=%h, want 1/0/11111111",
               instr_valid, pc, instr);
    end
  endtask

  // Reference: a fetch is "in flight" for the one cycle after a non-stalled
  // idle cycle; it lands as the next sequential word unless a redirect hits.
  task automatic test_random();
    logic        m_busy, m_valid, s, b;
    logic [31:0] m_next, m_pc, m_instr, t;
    do_reset();
    m_busy = 1'b0; m_valid = 1'b0; m_next = 32'd0; m_pc = 32'd0; m_instr = 32'd0;
    for (int c = 0; c < 400; c++) begin
      s = ($urandom_range(0, 2) == 0);
      b = ($urandom_range(0, 7) == 0);
`ifdef FETCH_ALIGN_CHECK_EN
      t = $urandom & 32'hFFFF_FFFC;
`else
      t = $urandom;
`endif
      stall = s; br = b; br_tgt = t;
      if (b) begin
        m_valid = 1'b0;
        m_busy  = 1'b0;
        m_next  = (t - (t % 4)) % 256;
      end else if (m_busy) begin
        m_instr = mem[m_next / 4];
        m_pc    = m_next;
        m_valid = 1'b1;
        m_next  = (m_next + 4) % 256;
        m_busy  = 1'b0;
      end else if (!s) begin
        m_valid = 1'b0;
        m_busy  = 1'b1;
      end
      tick(1);
      n_vec++;
      if (mem_en !== m_busy || mem_addr !== m_next || instr_valid !== m_valid ||
          pc !== m_pc || instr !== m_instr || fetch_err !== 1'b0) begin
        n_err++;
        $display("FAIL random c=%0d: en=%b addr=%0d valid=%b pc=%0d instr=%h err=%b, want en=%b addr=%0d valid=%b pc=%0d instr=%h err=0",
                 c, mem_en, mem_addr, instr_valid, pc, instr, fetch_err,
                 m_busy, m_next, m_valid, m_pc, m_instr);
      end
    end
    stall = 1'b0; br = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = $urandom;
    mem[0] = 32'h11111111;
    mem[1] = 32'h22222222;
    mem[2] = 32'h33333333;
    mem[3] = 32'h44444444;
    test_reset();
    test_sequential();
    test_stall();
    test_branch();
    test_wrap();
    test_align();
    test_reset_mid_access();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
